// File: rtl/nn_pkg.sv
// Shared types for the Architecture network and its feeder.
// Q8.8 words, feature vectors and the feeder state encoding.
package nn_pkg;

  localparam int FX_W  = 16;
  localparam int VEC_N = 6;

  typedef logic [FX_W-1:0] fx_t;
  typedef fx_t [VEC_N-1:0] vec_t;

  localparam fx_t LR_MIN = 16'h0001;
  localparam fx_t Q_ONE  = 16'h0100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_NEXT,
    S_FINISH
  } feed_state_t;

endpackage

// File: rtl/sample_mem.sv
// Sample store: one write port, one registered read port.
// Contents are not reset; only the read register is.
module sample_mem #(
  parameter int DEPTH = 32,
  parameter int W     = 112,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/train_feeder.sv
// Streams stored samples into the network with TR/VL pulses,
// waits on S_Train, counts errors and decays the learning rate.
module train_feeder
  import nn_pkg::*;
#(
  parameter int NX      = 6,
  parameter int BITS    = 16,
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 1024,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [NX*BITS-1:0] wr_x,
  input  logic [BITS-1:0]  wr_y,
  input  logic             start,
  input  logic             mode,
  input  logic [CW-1:0]    n_samples,
  input  logic [7:0]       n_epochs,
  input  logic [BITS-1:0]  lr_init,
  output logic [NX*BITS-1:0] x,
  output logic [BITS-1:0]  y,
  output logic [BITS-1:0]  lr,
  output logic             TR,
  output logic             VL,
  input  logic             S_Train,
  input  logic             S_Error,
  input  logic             yhat,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CW-1:0]    err_cnt,
  output logic [7:0]       epoch
);

  localparam int W  = NX*BITS + BITS;
  localparam int TW = $clog2(TIMEOUT + 1);

  feed_state_t state, state_n;

  logic          mode_q;
  logic [CW-1:0] nsamp_q;
  logic [7:0]    nep_q;
  logic [AW-1:0] idx;
  logic [TW-1:0] wcnt;
  logic [W-1:0]  rd;

  logic          tmo;
  logic          err_hit;
  logic          last;
  logic          stop;
  logic [7:0]    ep_n;
  logic [BITS-1:0] lr_half;

  sample_mem #(
    .DEPTH(DEPTH),
    .W(W)
  ) u_mem (
    .clk(clk),
    .rst(rst),
    .we(wr_en && state == S_IDLE),
    .waddr(wr_addr),
    .wdata({wr_x, wr_y}),
    .re(state == S_LOAD),
    .raddr(idx),
    .rdata(rd)
  );

  assign x = rd[W-1:BITS];
  assign y = rd[BITS-1:0];

  assign busy = state != S_IDLE;
  assign done = state == S_FINISH;

  always_comb begin
    tmo     = wcnt == TW'(TIMEOUT);
    err_hit = mode_q ? (yhat != (y != '0)) : S_Error;
    last    = {1'b0, idx} >= nsamp_q - CW'(1);
    ep_n    = epoch + 8'd1;
    stop    = (ep_n == nep_q) || (!mode_q && err_cnt == '0);
    // halve, but never let a nonzero rate reach zero
    if (lr == '0)
      lr_half = '0;
    else if (lr[BITS-1:1] == '0)
      lr_half = BITS'(LR_MIN);
    else
      lr_half = lr >> 1;
  end

  always_comb begin
    state_n = state;
    TR      = 1'b0;
    VL      = 1'b0;
    unique case (state)
      S_IDLE: if (start) state_n = S_LOAD;
      S_LOAD: state_n = S_ISSUE;
      S_ISSUE: begin
        TR      = !mode_q;
        VL      = mode_q;
        state_n = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (S_Train)  state_n = S_WAIT_DONE;
        else if (tmo) state_n = S_FINISH;
      end
      S_WAIT_DONE: begin
        if (!S_Train) state_n = S_NEXT;
        else if (tmo) state_n = S_FINISH;
      end
      S_NEXT: begin
        if (last && stop) state_n = S_FINISH;
        else              state_n = S_LOAD;
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      mode_q  <= 1'b0;
      nsamp_q <= '0;
      nep_q   <= '0;
      idx     <= '0;
      wcnt    <= '0;
      lr      <= '0;
      timeout <= 1'b0;
      err_cnt <= '0;
      epoch   <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            mode_q  <= mode;
            nsamp_q <= n_samples;
            nep_q   <= n_epochs;
            lr      <= lr_init;
            idx     <= '0;
            epoch   <= '0;
            err_cnt <= '0;
            timeout <= 1'b0;
          end
        end
        S_ISSUE: wcnt <= '0;
        S_WAIT_ACK: begin
          if (S_Train) wcnt <= '0;
          else begin
            wcnt <= wcnt + TW'(1);
            if (tmo) timeout <= 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!S_Train) begin
            if (err_hit && err_cnt != '1)
              err_cnt <= err_cnt + CW'(1);
          end else begin
            wcnt <= wcnt + TW'(1);
            if (tmo) timeout <= 1'b1;
          end
        end
        S_NEXT: begin
          if (!last) begin
            idx <= idx + AW'(1);
          end else begin
            epoch <= ep_n;
            idx   <= '0;
            if (!stop) begin
              err_cnt <= '0;
              lr      <= lr_half;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_train_feeder.sv
// Scoreboard bench for train_feeder with a cycle-level
// model of the network's S_Train/S_Error/yhat handshake.
module tb_train_feeder;
  import nn_pkg::*;

  localparam int NX    = 6;
  localparam int BITS  = 16;
  localparam int DEPTH = 32;
  localparam int TMO   = 32;
  localparam int AW    = 5;
  localparam int CW    = 6;
  localparam int XW    = NX*BITS;

  logic clk = 0;
  logic rst = 1;
  logic wr_en = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [XW-1:0] wr_x = '0;
  logic [15:0] wr_y = '0;
  logic start = 0;
  logic mode = 0;
  logic [CW-1:0] n_samples = '0;
  logic [7:0] n_epochs = '0;
  logic [15:0] lr_init = '0;
  logic [XW-1:0] x;
  logic [15:0] y;
  logic [15:0] lr;
  logic TR, VL;
  logic S_Train = 0;
  logic S_Error = 0;
  logic yhat = 0;
  logic busy, done, timeout;
  logic [CW-1:0] err_cnt;
  logic [7:0] epoch;

  train_feeder #(
    .NX(NX), .BITS(BITS), .DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_x(wr_x), .wr_y(wr_y),
    .start(start), .mode(mode),
    .n_samples(n_samples), .n_epochs(n_epochs),
    .lr_init(lr_init),
    .x(x), .y(y), .lr(lr),
    .TR(TR), .VL(VL),
    .S_Train(S_Train), .S_Error(S_Error), .yhat(yhat),
    .busy(busy), .done(done), .timeout(timeout),
    .err_cnt(err_cnt), .epoch(epoch)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          tr;
    logic [XW-1:0] x;
    logic [15:0]   y;
    logic [15:0]   lr;
  } iss_t;

  typedef struct packed {
    logic [CW-1:0] err;
    logic [7:0]    ep;
    logic          to;
  } fin_t;

  iss_t iss_q[$];
  fin_t fin_q[$];
  logic err_q[$];
  logic yh_q[$];
  logic [XW-1:0] mx [DEPTH];
  logic [15:0]   my [DEPTH];

  int checks = 0;
  int errors = 0;
  int tr_cnt = 0;
  int vl_cnt = 0;
  bit no_ack = 0;

  int m_ph = 0;
  int m_cnt = 0;
  logic m_e, m_y;
  logic [XW-1:0] m_x;
  logic [15:0] m_yv, m_lr;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event, expected none", nm);
  endtask

  // network model: ack 3 cycles after a pulse, busy for 5
  initial forever begin
    @(negedge clk);
    if (rst) begin
      S_Train = 0; S_Error = 0; yhat = 0; m_ph = 0;
    end else begin
      case (m_ph)
        0: if ((TR || VL) && !no_ack) begin
          m_e = (err_q.size() > 0) ? err_q.pop_front() : 1'b0;
          m_y = (yh_q.size() > 0) ? yh_q.pop_front() : 1'b0;
          m_x = x; m_yv = y; m_lr = lr;
          m_cnt = 1; m_ph = 1;
        end
        1: if (m_cnt == 3) begin
          S_Train = 1; S_Error = m_e; yhat = m_y;
          m_cnt = 1; m_ph = 2;
        end else m_cnt++;
        2: if (m_cnt == 5) begin
          S_Train = 0; m_ph = 3;
          chk("hold_x", x, m_x);
          chk("hold_y", y, m_yv);
          chk("hold_lr", lr, m_lr);
        end else m_cnt++;
        default: begin
          S_Error = 0; yhat = 0; m_ph = 0;
        end
      endcase
    end
  end

  // monitor: pops expected issues and run results
  initial forever begin
    iss_t ei;
    fin_t ef;
    @(negedge clk);
    if (!rst) begin
      if (TR || VL) begin
        tr_cnt += int'(TR);
        vl_cnt += int'(VL);
        if (iss_q.size() == 0) miss("issue");
        else begin
          ei = iss_q.pop_front();
          chk("pulse", {TR, VL}, {ei.tr, !ei.tr});
          chk("issue_x", x, ei.x);
          chk("issue_y", y, ei.y);
          chk("issue_lr", lr, ei.lr);
        end
      end
      if (done) begin
        if (fin_q.size() == 0) miss("done");
        else begin
          ef = fin_q.pop_front();
          chk("fin_err", err_cnt, ef.err);
          chk("fin_epoch", epoch, ef.ep);
          chk("fin_timeout", timeout, ef.to);
          chk("fin_busy", busy, 1'b1);
        end
      end
    end
  end

  task automatic wr(input int a, input logic [XW-1:0] xv,
                    input logic [15:0] yv);
    wr_en = 1; wr_addr = AW'(a); wr_x = xv; wr_y = yv;
    mx[a] = xv; my[a] = yv;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic kick(input logic m, input int ns, input int ne,
                      input logic [15:0] l0);
    mode = m; n_samples = CW'(ns);
    n_epochs = 8'(ne); lr_init = l0;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic push_iss(input logic t, input int a,
                          input logic [15:0] l);
    iss_q.push_back('{tr: t, x: mx[a], y: my[a], lr: l});
  endtask

  task automatic push_fin(input int e, input int ep, input logic t);
    fin_q.push_back('{err: CW'(e), ep: 8'(ep), to: t});
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1'b1);
    @(negedge clk);
    chk("busy_after", busy, 1'b0);
  endtask

  task automatic end_test(input string nm, input int etr, input int evl);
    repeat (3) @(negedge clk);
    chk({nm, "_iss_left"}, iss_q.size(), 0);
    chk({nm, "_fin_left"}, fin_q.size(), 0);
    chk({nm, "_tr"}, tr_cnt, etr);
    chk({nm, "_vl"}, vl_cnt, evl);
    tr_cnt = 0; vl_cnt = 0;
    err_q.delete(); yh_q.delete();
  endtask

  task automatic outs_zero(input string nm);
    chk({nm, "_x"}, x, '0);
    chk({nm, "_y"}, y, '0);
    chk({nm, "_lr"}, lr, '0);
    chk({nm, "_pulse"}, {TR, VL}, 2'b00);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_done"}, done, 1'b0);
    chk({nm, "_to"}, timeout, 1'b0);
    chk({nm, "_err"}, err_cnt, '0);
    chk({nm, "_epoch"}, epoch, '0);
  endtask

  initial begin
    int n, exp_err;
    logic [XW-1:0] xv;
    logic [15:0] lrs [4];

    repeat (3) @(negedge clk);
    outs_zero("reset");
    rst = 0;

    for (int a = 0; a < DEPTH; a++) begin
      for (int k = 0; k < NX; k++)
        xv[k*16 +: 16] = 16'(a*16 + k + 1);
      wr(a, xv, (a % 4 == 0) ? 16'h0000 : Q_ONE + 16'(a));
    end

    // single train sample
    wr(0, {16'hFEEF, 16'h0201, Q_ONE, Q_ONE, Q_ONE, Q_ONE}, Q_ONE);
    err_q.push_back(0);
    push_iss(1, 0, 16'h0002);
    push_fin(0, 1, 0);
    kick(0, 1, 1, 16'h0002);
    chk("busy_run", busy, 1'b1);
    wait_done(200);
    end_test("single", 1, 0);

    // lr decay and floor
    lrs = '{16'h0004, 16'h0002, 16'h0001, 16'h0001};
    for (int e = 0; e < 4; e++)
      for (int s = 0; s < 4; s++) begin
        err_q.push_back(1);
        push_iss(1, s, lrs[e]);
      end
    push_fin(4, 4, 0);
    kick(0, 4, 4, 16'h0004);
    wait_done(1000);
    end_test("decay", 16, 0);

    // early stop after first clean epoch
    for (int e = 0; e < 2; e++)
      for (int s = 0; s < 3; s++) begin
        err_q.push_back(e == 0);
        push_iss(1, s, e == 0 ? 16'h0100 : 16'h0080);
      end
    push_fin(0, 2, 0);
    kick(0, 3, 10, 16'h0100);
    wait_done(1000);
    end_test("early", 6, 0);

    // validate: second sample mispredicted
    wr(0, {6{16'h0011}}, Q_ONE);
    wr(1, {6{16'h0022}}, 16'h0000);
    yh_q.push_back(1); yh_q.push_back(1);
    push_iss(0, 0, 16'h0010);
    push_iss(0, 1, 16'h0010);
    push_fin(1, 1, 0);
    kick(1, 2, 1, 16'h0010);
    wait_done(500);
    end_test("valid", 0, 2);

    // timeout on a silent network
    no_ack = 1;
    push_iss(1, 0, 16'h0003);
    push_fin(0, 0, 1);
    kick(0, 1, 1, 16'h0003);
    n = 0;
    while (!TR && n < 10) begin @(negedge clk); n++; end
    n = 0;
    @(negedge clk);
    while (!timeout && n < 4*TMO) begin n++; @(negedge clk); end
    chk("to_cycles", n, TMO + 1);
    chk("to_done", done, 1'b1);
    repeat (3) @(negedge clk);
    chk("to_sticky", timeout, 1'b1);
    end_test("tmo", 1, 0);
    no_ack = 0;
    err_q.push_back(0);
    push_iss(1, 0, 16'h0003);
    push_fin(0, 1, 0);
    kick(0, 1, 1, 16'h0003);
    chk("to_clear", timeout, 1'b0);
    wait_done(200);
    end_test("retry", 1, 0);

    // reset mid-run during sample 2
    err_q.push_back(0); err_q.push_back(0); err_q.push_back(0);
    push_iss(1, 0, 16'h0040);
    push_iss(1, 1, 16'h0040);
    kick(0, 3, 1, 16'h0040);
    n = 0;
    while (tr_cnt < 2 && n < 500) begin @(negedge clk); n++; end
    while (!S_Train && n < 500) begin @(negedge clk); n++; end
    chk("mid_reached", n < 500, 1'b1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    outs_zero("midrst");
    rst = 0;
    wr(0, {6{16'h0abc}}, 16'h0def);
    end_test("midrst", 2, 0);
    yh_q.push_back(1);
    push_iss(0, 0, 16'h0020);
    push_fin(0, 1, 0);
    kick(1, 1, 1, 16'h0020);
    wait_done(200);
    end_test("postrst", 0, 1);

    // last-address write with start, full-depth validate
    wr_en = 1; wr_addr = AW'(DEPTH-1);
    wr_x = {6{16'h7777}}; wr_y = 16'h0000;
    mx[DEPTH-1] = wr_x; my[DEPTH-1] = wr_y;
    exp_err = 0;
    for (int a = 0; a < DEPTH; a++) begin
      yh_q.push_back(1);
      push_iss(0, a, 16'h0100);
      exp_err += int'(my[a] == 16'h0000);
    end
    push_fin(exp_err, 1, 0);
    kick(1, DEPTH, 1, 16'h0100);
    wr_en = 0;
    wait_done(3000);
    end_test("full", 0, DEPTH);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/train_feeder.md
# train_feeder

Upstream sequencer for the `Architecture` network. It holds a small sample store of Q8.8 input vectors and labels, and streams them one sample at a time into the network's `x`/`y`/`lr` inputs. Each sample is issued with a `TR` or `VL` pulse, and the feeder waits for the network's `S_Train` handshake before moving on. It counts per-epoch errors, halves the learning rate each epoch, and stops after a fixed epoch count or after the first error-free epoch.

## Interface
Parameters:
- `NX`, 6: number of input features
- `BITS`, 16: Q8.8 word width
- `DEPTH`, 32: sample store depth
- `TIMEOUT`, 1024: maximum cycles to wait on any one handshake phase

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, synchronous and active-high
- `wr_en` in 1: sample store write strobe
- `wr_addr` in clog2(DEPTH): write address
- `wr_x` in NX×BITS: sample features
- `wr_y` in BITS: sample label
- `start` in 1: start a run; sampled only in IDLE
- `mode` in 1: run type; 0 = train (pulse `TR`), 1 = validate (pulse `VL`); latched at start
- `n_samples` in clog2(DEPTH)+1: samples per epoch, 1..DEPTH; latched at start
- `n_epochs` in 8: number of epochs, ≥1; latched at start
- `lr_init` in BITS: initial learning rate
- `x` out NX×BITS: features to the network
- `y` out BITS: label to the network
- `lr` out BITS: learning rate to the network
- `TR` out 1: train pulse
- `VL` out 1: validate pulse
- `S_Train` in 1: network busy flag
- `S_Error` in 1: network error flag
- `yhat` in 1: network prediction
- `busy` out 1: high from start until the end of the run
- `done` out 1: one-cycle pulse at the end of the run
- `timeout` out 1: sticky; cleared by `start`
- `err_cnt` out clog2(DEPTH)+1: errors in the current or most recent epoch
- `epoch` out 8: number of completed epochs

## Operation
States: IDLE, LOAD, ISSUE, WAIT_ACK, WAIT_DONE, NEXT, FINISH.
- **IDLE**
  - `wr_en` writes `wr_x`/`wr_y` at `wr_addr`.
  - Writes are ignored in every other state.
  - `start` → LOAD. Latches `mode`, `n_samples`, `n_epochs`; sets `lr` ← `lr_init`; sample index ← 0; `epoch` ← 0; `err_cnt` ← 0.
- **LOAD**
  - Registered store read of the current index; `x`/`y` updated.
  - → ISSUE.
- **ISSUE**
  - `TR` (mode 0) or `VL` (mode 1) high for exactly this cycle.
  - → WAIT_ACK.
- **WAIT_ACK**
  - Waits for `S_Train` = 1, then → WAIT_DONE.
- **WAIT_DONE**
  - Waits for `S_Train` = 0.
  - On that cycle, an error is counted when (mode 0: `S_Error` = 1) or (mode 1: `yhat` ≠ (`y` ≠ 0)). `err_cnt` saturates.
  - → NEXT.
- **NEXT**
  - If index < `n_samples`−1: index+1, → LOAD.
  - Otherwise the epoch ends: `epoch`+1, index ← 0.
    - If `epoch` reaches `n_epochs`, or the epoch just ended had `err_cnt` = 0 in mode 0: → FINISH.
    - Else: `err_cnt` ← 0; `lr` ← `lr`>>1, floored at 16'h0001 (no change if `lr` = 0); → LOAD.
- **FINISH**
  - `done` pulse, `busy` ← 0, → IDLE.
  - `err_cnt` and `epoch` hold until the next `start`.
- **Timeout:** a WAIT_ACK or WAIT_DONE phase that exceeds `TIMEOUT` cycles sets `timeout` and → FINISH.
- `x`, `y` and `lr` are held stable from ISSUE through the exit from WAIT_DONE.

## Timing
- **Reset values:** all outputs 0; state IDLE. Store contents are not reset.
- **Reset mid-run:** abandons the run within one cycle. `TR`/`VL` are deasserted and no `done` pulse is generated.
- **Sample start:** LOAD→ISSUE adds 2 cycles before the handshake.
- **Sample cost:** ≥ 2 + 1 + handshake + 1 (NEXT) cycles per sample.
- **`S_Train` already high in ISSUE:** WAIT_ACK exits on the first cycle.
- **Back-to-back `start`:** `start` while busy is ignored. `start` in the cycle FINISH returns to IDLE is taken on the next IDLE cycle.
- **Write to the last address:** a `wr_en` to address DEPTH−1 in the same cycle as `start` is committed, and `start` still proceeds.
- **Run with `n_samples` = 1:** valid; every epoch is one sample.

## Structure
- Shared package `nn_pkg`:
  - fixed-point word typedef (BITS=16, Q8.8)
  - vector typedef NX×BITS
  - `LR_MIN` = 16'h0001
  - `Q_ONE` = 16'h0100
  - feeder state enum
- One sub-module `sample_mem`: DEPTH-entry, 1 write port, 1 registered read port, width NX·BITS+BITS.

## Test plan
- **Load and single train sample:** load 1 sample (x = {FEEF, 0201, 0100×4}, y = 0100); `lr_init` = 0002, `n_epochs` = 1, mode 0; model asserts `S_Train` 3 cycles after `TR` for 5 cycles with `S_Error` = 0. Expect one `TR` pulse, `x` unchanged through the handshake, `err_cnt` = 0, `epoch` = 1, a single `done` pulse.
- **LR decay and floor:** 4 samples, 4 epochs; `S_Error` = 1 on every sample; `lr_init` = 0004. Expect `lr` = 0004, 0002, 0001, 0001 across the epochs, `err_cnt` = 4 at the end, `epoch` = 4.
- **Early stop:** 3 samples, 10 epochs; errors in epoch 0 only. Expect `done` after `epoch` = 2 and a total of 6 `TR` pulses.
- **Validate:** mode 1, 2 samples with y = 0100 and 0000; model returns `yhat` = 1, 1. Expect only `VL` pulses (no `TR`), `err_cnt` = 1, `epoch` = 1.
- **Timeout:** `S_Train` held at 0 after `TR`. Expect `timeout` = 1 at `TIMEOUT`+1 cycles, followed by `done`; the next `start` clears `timeout`.
- **Reset mid-run:** assert `rst` during WAIT_DONE of sample 2. Expect all outputs 0 on the next cycle, no `done` pulse, and `wr_en` accepted immediately after reset.
